pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Hazard and stall controller for the 5-stage RV32I pipeline. It generates per-stage enables and flushes, registered EX-stage forwarding selects, and a WB→ID register bypass. It also supports a configurable multi-cycle data-memory wait. It sits beside the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers and drives their enable/flush inputs and the EX operand muxes.

## Interface
Parameters:
- REG_ADDR_W, 5, register index width
- MEM_WAIT, 0, extra stall cycles per data-memory access (0 = single-cycle memory)
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  the ID instruction actually reads the register
- ex_rd  in  REG_ADDR_W, ex_regwrite  in  1, ex_memread  in  1  destination info of the instruction in EX
- mem_rd  in  REG_ADDR_W, mem_regwrite  in  1  destination info of the instruction in MEM
- wb_rd  in  REG_ADDR_W, wb_regwrite  in  1  destination info of the instruction in WB
- mem_access  in  1  MEM instruction is a load or store
- mem_pcsrc  in  1  taken branch resolved in MEM
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1  stage-register load enables
- ifid_flush, idex_flush, exmem_flush  out  1  load a bubble (all controls 0) at the next edge
- fwd_a, fwd_b  out  2  registered EX operand selects: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB write data
- id_byp_a, id_byp_b  out  1  in ID, substitute the WB write data for the register-file read
- stall_cycles, flush_events  out  CNT_W  performance counters

## Operation
- States: RUN and WAIT. A down-counter `cnt` is ceil(log2(MEM_WAIT+1)) bits wide, minimum 1.
- mem_stall is `(RUN & mem_access & MEM_WAIT>0) | (WAIT & cnt!=0)`.
  - In RUN, when mem_stall is set: load `cnt` with MEM_WAIT-1 and go to WAIT.
  - In WAIT with `cnt!=0`: decrement `cnt`.
  - In WAIT with `cnt==0`: this is the release cycle. The pipeline advances and the state returns to RUN.
- While mem_stall is set: all five enables are 0 and all flushes are 0. This has top priority.
- Branch (mem_pcsrc, no mem_stall):
  - ifid_flush, idex_flush and exmem_flush are set to 1.
  - All enables are 1.
  - The load-use condition is ignored.
- Load-use:
  - Condition: ex_memread & ex_regwrite & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=0, ifid_en=0, idex_flush=1; other enables are 1.
- Otherwise all enables are 1 and all flushes are 0.
- Forwarding is computed in ID and registered into the fwd_a/fwd_b flops on any edge where idex_en=1.
  - Select 01: ex_regwrite & !ex_memread & ex_rd!=0 & ex_rd==rs.
  - Else select 10: mem_regwrite & mem_rd!=0 & mem_rd==rs.
  - Else select 00.
  - When idex_flush=1, the flops load 00.
  - When idex_en=0, the flops hold.
- id_byp_a is combinational: wb_regwrite & wb_rd!=0 & wb_rd==id_rs1. id_byp_b is the same using id_rs2.
- Register index 0 never forwards or stalls.

## Timing
- Enables, flushes and id_byp outputs are combinational from inputs and state.
- fwd_a/fwd_b are valid in the cycle the instruction occupies EX (one-edge latency).
- Each memory access occupies MEM for MEM_WAIT+1 cycles, of which exactly MEM_WAIT are stall cycles.
- Back-to-back accesses each incur a full MEM_WAIT stall. The release cycle is the only non-stalled cycle between them.
- Load-use costs exactly one bubble.
- A taken branch costs exactly three squashed instructions.
- Reset: state RUN, `cnt` 0, fwd_a/fwd_b 00, counters 0. With all inputs 0: enables are 1 and flushes are 0.
- Reset asserted mid-WAIT returns the block to RUN immediately (asynchronous).

## Configuration
- PIPE_PERF_CNT_EN defined:
  - stall_cycles increments on every cycle with pc_en=0.
  - flush_events increments on every cycle with mem_pcsrc=1 and no mem_stall.
  - Both counters saturate at all-ones.
- Not defined: both outputs are constant 0 and no counter flops are built.

## Test plan
- MEM_WAIT=0. Consumer reads x5 in ID while EX writes x5 (ALU op) → next cycle fwd_a=01. The same case with the producer in MEM → fwd_a=10. Producer rd=x0 → fwd_a=00.
- Load to x7 in EX, ID reads x7 → exactly one cycle with pc_en=0, ifid_en=0, idex_flush=1. The following cycle has fwd=00 for the bubble, then fwd=10 for the consumer.
- mem_pcsrc=1 pulse → ifid/idex/exmem_flush=1 for one cycle with the load-use condition also true. pc_en=1; flush_events goes 0→1.
- MEM_WAIT=3, mem_access held high for 4 cycles → enables 0 for 3 cycles, then 1. stall_cycles=3. A second access immediately after → another 3 stall cycles.
- MEM_WAIT=3, rst driven low in the second stall cycle → enables return to 1 asynchronously. State is RUN, fwd=00, counters 0.
- WB writes x9 while ID reads x9 on rs2 → id_byp_b=1 in the same cycle, and id_byp_a=0.

Source files
------------

// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath side is the master and the controller is the slave.
interface pipe_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 32
);
  logic [REG_ADDR_W-1:0] id_rs1;
  logic [REG_ADDR_W-1:0] id_rs2;
  logic                  id_use_rs1;
  logic                  id_use_rs2;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  ex_regwrite;
  logic                  ex_memread;
  logic [REG_ADDR_W-1:0] mem_rd;
  logic                  mem_regwrite;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic                  wb_regwrite;
  logic                  mem_access;
  logic                  mem_pcsrc;
  logic                  pc_en;
  logic                  ifid_en;
  logic                  idex_en;
  logic                  exmem_en;
  logic                  memwb_en;
  logic                  ifid_flush;
  logic                  idex_flush;
  logic                  exmem_flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic                  id_byp_a;
  logic                  id_byp_b;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    output ex_rd, ex_regwrite, ex_memread,
    output mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    output mem_access, mem_pcsrc,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    input  ifid_flush, idex_flush, exmem_flush,
    input  fwd_a, fwd_b, id_byp_a, id_byp_b,
    input  stall_cycles, flush_events
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2,
    input  ex_rd, ex_regwrite, ex_memread,
    input  mem_rd, mem_regwrite, wb_rd, wb_regwrite,
    input  mem_access, mem_pcsrc,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
    output ifid_flush, idex_flush, exmem_flush,
    output fwd_a, fwd_b, id_byp_a, id_byp_b,
    output stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// 5-stage RV32I hazard/stall controller with multi-cycle data-memory wait.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int MEM_WAIT   = 0,
  parameter int CNT_W      = 32
) (
  input logic          clk,
  input logic          rst,
  pipe_hazard_if.slave hz
);
  localparam int CW = (MEM_WAIT > 1) ? $clog2(MEM_WAIT + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT =
    (MEM_WAIT > 0) ? CW'(MEM_WAIT - 1) : '0;
  localparam bit HAS_WAIT = (MEM_WAIT > 0);
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic {S_RUN, S_WAIT} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      fwd_a_q, fwd_a_d;
  logic [1:0]      fwd_b_q, fwd_b_d;
  logic [1:0]      sel_a, sel_b;
  logic            mem_stall, load_use;
  logic            do_br, do_lu;
  logic            ex_ok, mem_ok;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, exmem_flush;

  assign mem_stall =
    (state_q == S_RUN && hz.mem_access && HAS_WAIT) ||
    (state_q == S_WAIT && cnt_q != '0);

  assign load_use =
    hz.ex_memread && hz.ex_regwrite && hz.ex_rd != X0 &&
    ((hz.id_use_rs1 && hz.id_rs1 == hz.ex_rd) ||
     (hz.id_use_rs2 && hz.id_rs2 == hz.ex_rd));

  assign do_br = hz.mem_pcsrc && !mem_stall;
  assign do_lu = load_use && !hz.mem_pcsrc && !mem_stall;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          cnt_d   = CNT_INIT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else state_d = S_RUN;
      end
      default: state_d = S_RUN;
    endcase
  end

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    unique case (1'b1)
      mem_stall: begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        exmem_en = 1'b0;
        memwb_en = 1'b0;
      end
      do_br: begin
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end
      do_lu: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
      default: ;
    endcase
  end

  // Loads are not forwarded from EX; that case is the load-use stall.
  assign ex_ok  = hz.ex_regwrite && !hz.ex_memread && hz.ex_rd != X0;
  assign mem_ok = hz.mem_regwrite && hz.mem_rd != X0;

  always_comb begin
    sel_a = 2'b00;
    sel_b = 2'b00;
    if (ex_ok && hz.ex_rd == hz.id_rs1) sel_a = 2'b01;
    else if (mem_ok && hz.mem_rd == hz.id_rs1) sel_a = 2'b10;
    if (ex_ok && hz.ex_rd == hz.id_rs2) sel_b = 2'b01;
    else if (mem_ok && hz.mem_rd == hz.id_rs2) sel_b = 2'b10;
    fwd_a_d = fwd_a_q;
    fwd_b_d = fwd_b_q;
    if (idex_flush) begin
      fwd_a_d = 2'b00;
      fwd_b_d = 2'b00;
    end else if (idex_en) begin
      fwd_a_d = sel_a;
      fwd_b_d = sel_b;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0] flush_events_q, flush_events_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_events_d = flush_events_q;
    if (!pc_en && stall_cycles_q != '1)
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    if (do_br && flush_events_q != '1)
      flush_events_d = flush_events_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles_q <= '0;
      flush_events_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_events_q <= flush_events_d;
    end
  end

  assign hz.stall_cycles = stall_cycles_q;
  assign hz.flush_events = flush_events_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

  assign hz.pc_en       = pc_en;
  assign hz.ifid_en     = ifid_en;
  assign hz.idex_en     = idex_en;
  assign hz.exmem_en    = exmem_en;
  assign hz.memwb_en    = memwb_en;
  assign hz.ifid_flush  = ifid_flush;
  assign hz.idex_flush  = idex_flush;
  assign hz.exmem_flush = exmem_flush;
  assign hz.fwd_a       = fwd_a_q;
  assign hz.fwd_b       = fwd_b_q;
  assign hz.id_byp_a    =
    hz.wb_regwrite && hz.wb_rd != X0 && hz.wb_rd == hz.id_rs1;
  assign hz.id_byp_b    =
    hz.wb_regwrite && hz.wb_rd != X0 && hz.wb_rd == hz.id_rs2;
endmodule
